// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one multi-cycle memory between I-cache fills, D-cache
// fills and D-side write-through stores. Define ARB_RR_EN for D/I round-robin.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic                           d_wr,
  input  logic [DATA_W-1:0]              d_wdata,
  output logic                           i_grant,
  output logic                           d_grant,
  output logic                           d_wr_ack,
  output logic                           fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           fill_done,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_valid
);

  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = WORD_W + 1;
  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_e;
  typedef enum logic {SIDE_D, SIDE_I} side_e;

  state_e              state_q, state_d;
  side_e               dst_q, dst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [WORD_W-1:0]   rcv_q, rcv_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                d_req, pick_i, issuing, accept;
`ifdef ARB_RR_EN
  side_e               rr_q, rr_d;
`endif

  assign d_req = d_wr | d_miss;
`ifdef ARB_RR_EN
  // rr_q names the side that wins a D-vs-I tie.
  assign pick_i = i_miss & (~d_req | (rr_q == SIDE_I));
`else
  assign pick_i = i_miss & ~d_req;
`endif

  assign issuing = (state_q == FILL) && (issue_q < CNT_W'(BLOCK_WORDS));
  // No read of this fill can return before MEM_LAT cycles have elapsed, so an
  // earlier mem_valid is a leftover from an aborted transaction and is dropped.
  assign accept  = (state_q == FILL) && mem_valid && (lat_q == LAT_W'(MEM_LAT));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    issue_d = issue_q;
    rcv_d   = rcv_q;
    lat_d   = lat_q;
`ifdef ARB_RR_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        issue_d = '0;
        rcv_d   = '0;
        lat_d   = '0;
        if (pick_i) begin
          state_d = FILL;
          dst_d   = SIDE_I;
          addr_d  = i_addr;
        end else if (d_wr) begin
          state_d = WRITE;
          dst_d   = SIDE_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (d_miss) begin
          state_d = FILL;
          dst_d   = SIDE_D;
          addr_d  = d_addr;
        end
`ifdef ARB_RR_EN
        if (pick_i) rr_d = SIDE_D;
        else if (d_req) rr_d = SIDE_I;
`endif
      end
      WRITE: state_d = IDLE;
      FILL: begin
        if (issuing) issue_d = issue_q + 1'b1;
        if (lat_q != LAT_W'(MEM_LAT)) lat_d = lat_q + 1'b1;
        if (accept) begin
          rcv_d = rcv_q + 1'b1;
          if (rcv_q == WORD_W'(BLOCK_WORDS - 1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_grant    = 1'b0;
    d_grant    = 1'b0;
    d_wr_ack   = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_word  = '0;
    fill_data  = '0;
    fill_done  = 1'b0;
    case (state_q)
      WRITE: begin
        d_grant   = 1'b1;
        d_wr_ack  = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q & ~ADDR_W'(1);
        mem_wdata = wdata_q;
      end
      FILL: begin
        i_grant = (dst_q == SIDE_I);
        d_grant = (dst_q == SIDE_D);
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = (addr_q & ~BLOCK_MASK) | ADDR_W'({issue_q[WORD_W-1:0], 1'b0});
        end
        if (accept) begin
          fill_valid = 1'b1;
          fill_word  = rcv_q;
          fill_data  = mem_rdata;
          fill_done  = (rcv_q == WORD_W'(BLOCK_WORDS - 1));
        end
      end
      default: ;
    endcase
  end

  // NOTE: reset is asynchronous, so an abort clears state (and thus every output) at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dst_q   <= SIDE_D;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      rcv_q   <= '0;
      lat_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      rcv_q   <= rcv_d;
      lat_q   <= lat_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= SIDE_D;
    else     rr_q <= rr_d;
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a MEM_LAT-deep read pipeline model.
module tb_cache_mem_arbiter;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT     = 4;
`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_miss, d_miss, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_grant, d_grant, d_wr_ack, fill_valid, fill_done;
  logic [2:0]        fill_word;
  logic [DATA_W-1:0] fill_data, mem_wdata, mem_rdata;
  logic              mem_en, mem_wr, mem_valid;
  logic [ADDR_W-1:0] mem_addr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BLOCK_WORDS), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant), .d_wr_ack(d_wr_ack),
    .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
    .fill_done(fill_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  // Memory model: read data is a fixed function of address; not reset by rst.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  logic [MEM_LAT-1:0] pipe_v = '0;
  logic [ADDR_W-1:0]  pipe_a [MEM_LAT];
  logic               spur_v = 1'b0;

  initial for (int i = 0; i < MEM_LAT; i++) pipe_a[i] = '0;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MEM_LAT-2:0], mem_en & ~mem_wr};
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign mem_valid = pipe_v[MEM_LAT-1] | spur_v;
  assign mem_rdata = mem_fn(pipe_a[MEM_LAT-1]);

  // Passive monitor, sampled on the falling edge.
  int                cyc = 0;
  int                done_cnt = 0;
  int                first_iss_cyc = 0;
  int                done_cyc = 0;
  int                done_word = 0;
  logic [ADDR_W-1:0] iss_q[$];
  logic [1:0]        iss_gnt_q[$];
  int                fw_q[$];
  logic [DATA_W-1:0] fd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mem_en && !mem_wr) begin
      if (iss_q.size() == 0) first_iss_cyc = cyc;
      iss_q.push_back(mem_addr);
      iss_gnt_q.push_back({i_grant, d_grant});
    end
    if (fill_valid) begin
      fw_q.push_back(int'(fill_word));
      fd_q.push_back(fill_data);
    end
    if (fill_done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_word = int'(fill_word);
    end
  end

  task automatic clear_log();
    iss_q.delete();
    iss_gnt_q.delete();
    fw_q.delete();
    fd_q.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fill(input int budget, output bit ok);
    int start = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Number of discrepancies between the logged fill and the expected block.
  function automatic int fill_errs(input logic [ADDR_W-1:0] base, input logic [1:0] gnt);
    int e = 0;
    if (iss_q.size() != BLOCK_WORDS) e++;
    if (fw_q.size() != BLOCK_WORDS) e++;
    foreach (iss_q[k]) begin
      if (iss_q[k] !== base + ADDR_W'(2 * k)) e++;
      if (iss_gnt_q[k] !== gnt) e++;
    end
    foreach (fw_q[k]) begin
      if (fw_q[k] != k) e++;
      if (fd_q[k] !== mem_fn(base + ADDR_W'(2 * k))) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [6:0] ctl;
    i_miss = 1'b1; i_addr = 16'h1111; d_wr = 1'b1; d_addr = 16'h2222;
    tick(); tick();
    ctl = {i_grant, d_grant, d_wr_ack, fill_valid, fill_done, mem_en, mem_wr};
    tests_run++;
    if (ctl !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b expected 0000000", ctl);
    end
    tests_run++;
    if ({mem_addr, mem_wdata, fill_data, fill_word} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h fdata=%h fword=%0d expected all 0",
               mem_addr, mem_wdata, fill_data, fill_word);
    end
    i_miss = 1'b0; d_wr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (mem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_req: mem_en got %b expected 0", mem_en);
    end
  endtask

  task automatic test_i_fill();
    bit ok;
    int errs;
    clear_log();
    i_miss = 1'b1; i_addr = 16'h1236;
    wait_fill(40, ok);
    i_miss = 1'b0;
    errs = fill_errs(16'h1230, 2'b10);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL i_fill_timeout: got no fill_done expected one within 40 cycles");
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++;
      $display("FAIL i_fill_data: got %0d discrepancies expected 0", errs);
    end
    tests_run++;
    if (done_cyc - first_iss_cyc !== 11) begin
      tests_failed++;
      $display("FAIL i_fill_latency: got %0d expected 11", done_cyc - first_iss_cyc);
    end
    tests_run++;
    if (done_word !== 7) begin
      tests_failed++;
      $display("FAIL i_fill_done_word: got %0d expected 7", done_word);
    end
    tick(); tick();
  endtask

  task automatic test_d_write();
    d_wr = 1'b1; d_addr = 16'h0041; d_wdata = 16'hBEEF;
    tick();
    tests_run++;
    if ({mem_en, mem_wr, d_wr_ack, d_grant, i_grant} !== 5'b11110) begin
      tests_failed++;
      $display("FAIL wr_ctl: got %b expected 11110",
               {mem_en, mem_wr, d_wr_ack, d_grant, i_grant});
    end
    tests_run++;
    if ({mem_addr, mem_wdata} !== {16'h0040, 16'hBEEF}) begin
      tests_failed++;
      $display("FAIL wr_addr_data: got %h/%h expected 0040/beef", mem_addr, mem_wdata);
    end
    d_wr = 1'b0;
    tick();
    tests_run++;
    if ({mem_en, d_wr_ack, d_grant} !== 3'b000) begin
      tests_failed++;
      $display("FAIL wr_after: got %b expected 000", {mem_en, d_wr_ack, d_grant});
    end
  endtask

  task automatic test_priority();
    bit ok1, ok2;
    int errs1, errs2, prev_done;
    bit first_i = RR_EN;
    clear_log();
    i_miss = 1'b1; i_addr = 16'h8889; d_miss = 1'b1; d_addr = 16'h4444;
    wait_fill(40, ok1);
    errs1 = first_i ? fill_errs(16'h8880, 2'b10) : fill_errs(16'h4440, 2'b01);
    if (first_i) i_miss = 1'b0; else d_miss = 1'b0;
    prev_done = done_cyc;
    clear_log();
    wait_fill(40, ok2);
    errs2 = first_i ? fill_errs(16'h4440, 2'b01) : fill_errs(16'h8880, 2'b10);
    i_miss = 1'b0; d_miss = 1'b0;
    tests_run++;
    if (!(ok1 && ok2)) begin
      tests_failed++;
      $display("FAIL prio_timeout: got done1=%b done2=%b expected 1/1", ok1, ok2);
    end
    tests_run++;
    if (errs1 !== 0) begin
      tests_failed++;
      $display("FAIL prio_first: got %0d discrepancies expected 0 (first_i=%b)", errs1, first_i);
    end
    tests_run++;
    if (errs2 !== 0) begin
      tests_failed++;
      $display("FAIL prio_second: got %0d discrepancies expected 0", errs2);
    end
    tests_run++;
    if (first_iss_cyc - prev_done !== 3) begin
      tests_failed++;
      $display("FAIL prio_gap: got %0d expected 3", first_iss_cyc - prev_done);
    end
    tick(); tick();
  endtask

  task automatic test_wr_over_miss();
    bit ok;
    int errs;
    d_wr = 1'b1; d_miss = 1'b1; d_addr = 16'h0123; d_wdata = 16'h1357;
    tick();
    tests_run++;
    if ({mem_en, mem_wr, d_wr_ack, mem_addr} !== {3'b111, 16'h0122}) begin
      tests_failed++;
      $display("FAIL wr_beats_miss: got en/wr/ack=%b addr=%h expected 111/0122",
               {mem_en, mem_wr, d_wr_ack}, mem_addr);
    end
    d_wr = 1'b0;
    clear_log();
    wait_fill(40, ok);
    d_miss = 1'b0;
    errs = fill_errs(16'h0120, 2'b01);
    tests_run++;
    if (!ok || errs !== 0) begin
      tests_failed++;
      $display("FAIL miss_after_wr: got done=%b discrepancies=%0d expected 1/0", ok, errs);
    end
    tick(); tick();
  endtask

  task automatic test_drop_and_spurious();
    bit ok, reached = 1'b0;
    int errs;
    clear_log();
    i_miss = 1'b1; i_addr = 16'h2A5F;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (iss_q.size() == 3) begin
        reached = 1'b1;
        break;
      end
    end
    i_miss = 1'b0;
    wait_fill(40, ok);
    errs = fill_errs(16'h2A50, 2'b10);
    tests_run++;
    if (!reached || !ok || errs !== 0) begin
      tests_failed++;
      $display("FAIL drop_mid_fill: got reached=%b done=%b discrepancies=%0d expected 1/1/0",
               reached, ok, errs);
    end
    tick(); tick();
    spur_v = 1'b1;
    #1;
    tests_run++;
    if ({fill_valid, fill_done, mem_en, fill_word, fill_data} !== '0) begin
      tests_failed++;
      $display("FAIL spurious_valid: got fv=%b fd=%b en=%b word=%0d data=%h expected all 0",
               fill_valid, fill_done, mem_en, fill_word, fill_data);
    end
    tick();
    spur_v = 1'b0;
    tests_run++;
    if (fw_q.size() !== BLOCK_WORDS) begin
      tests_failed++;
      $display("FAIL spurious_count: got %0d fill words expected %0d", fw_q.size(), BLOCK_WORDS);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok, reached = 1'b0;
    int errs, nfv = 0, nmv = 0;
    clear_log();
    i_miss = 1'b1; i_addr = 16'h3000;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (fw_q.size() == 5) begin
        reached = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (!reached || {i_grant, d_grant, fill_valid, fill_done, mem_en, mem_wr, d_wr_ack} !== 7'b0
        || {mem_addr, fill_word, fill_data} !== '0) begin
      tests_failed++;
      $display("FAIL rst_abort: got reached=%b gi=%b gd=%b fv=%b en=%b addr=%h expected 1 and all 0",
               reached, i_grant, d_grant, fill_valid, mem_en, mem_addr);
    end
    i_miss = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nfv += int'(fill_valid);
      nmv += int'(mem_valid);
      tick();
    end
    tests_run++;
    if (nfv !== 0 || nmv == 0) begin
      tests_failed++;
      $display("FAIL rst_stale_valid: got fill_valids=%0d (mem_valids=%0d) expected 0 (>0)",
               nfv, nmv);
    end
    clear_log();
    d_miss = 1'b1; d_addr = 16'h0F08;
    wait_fill(40, ok);
    d_miss = 1'b0;
    errs = fill_errs(16'h0F00, 2'b01);
    tests_run++;
    if (!ok || errs !== 0) begin
      tests_failed++;
      $display("FAIL rst_refill: got done=%b discrepancies=%0d expected 1/0", ok, errs);
    end
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_i_fill();
    test_d_write();
    test_priority();
    test_wr_over_miss();
    test_drop_and_spurious();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
